fetch_unit: RTL and testbench

Instruction-fetch stage of the 16-bit pipeline. It owns the program counter, issues requests to instruction memory over a req/ack handshake, and buffers returned instructions in a 2-entry queue. It presents each instruction to decode with its PC and PC+2, and redirects on the branch resolver's `pc_src`/`jump_address`, discarding stale or in-flight fetches.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 23 ++
 rtl/fetch_buffer.sv | 57 +++++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipeline front end.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Sequential successor of a halfword-aligned address, wrapping at 2^16.
  function automatic logic [ADDR_W-1:0] pc_plus_two(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(2);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch and memory.
interface fetch_unit_if;

  logic                         imem_req;
  logic [cpu_pkg::ADDR_W-1:0]   imem_addr;
  logic                         imem_ack;
  logic [cpu_pkg::INSTR_W-1:0]  imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry shift FIFO holding fetched instructions; the head slot is
// a register and drives decode directly.
module fetch_buffer
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t tail;

  // Flush wins over push; simultaneous push and pop keeps occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head  <= din;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            tail  <= din;
            count <= 2'd2;
          end
        end
        2'b01: begin
          if (count != 2'd0) begin
            head  <= tail;
            count <= count - 2'd1;
          end
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= din;
          end else begin
            head  <= din;
            count <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues memory requests, queues
// returned words for decode and handles branch redirects.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pc_src,
  input  logic [ADDR_W-1:0]   jump_address,
  fetch_unit_if.master        imem,
  output logic                if_valid,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [ADDR_W-1:0]   if_pc,
  output logic [ADDR_W-1:0]   if_pc_plus_two,
  input  logic                id_ready
);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [ADDR_W-1:0] target;
  logic              push, pop, room;
  logic [2:0]        count_next;
  logic [1:0]        count;
  fetch_entry_t      head;
  fetch_entry_t      din;

  // Queue control and the occupancy the queue will have after this edge.
  always_comb begin
    target     = {jump_address[ADDR_W-1:1], 1'b0};
    pop        = if_valid && id_ready && !pc_src;
    push       = (state == REQ) && imem.imem_ack && !pc_src;
    din.instr  = imem.imem_rdata;
    din.pc     = addr_q;
    count_next = pc_src ? 3'd0
                        : ({1'b0, count} + {2'b00, push} - {2'b00, pop});
    room       = count_next < 3'(BUF_DEPTH);
  end

  // Next-state, next fetch PC and next request address.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    addr_next     = addr_q;
    if (pc_src) fetch_pc_next = target;
    case (state)
      IDLE: begin
        if (pc_src) begin
          state_next = REQ;
          addr_next  = target;
        end else if (room) begin
          state_next = REQ;
          addr_next  = fetch_pc;
        end
      end
      REQ: begin
        if (pc_src) begin
          // An ack coinciding with the redirect is simply dropped, so the
          // new request can go out straight away; otherwise wait it out.
          if (imem.imem_ack) addr_next  = target;
          else               state_next = DROP;
        end else if (imem.imem_ack) begin
          fetch_pc_next = pc_plus_two(addr_q);
          if (room) addr_next  = fetch_pc_next;
          else      state_next = IDLE;
        end
      end
      DROP: begin
        if (imem.imem_ack) begin
          state_next = REQ;
          addr_next  = fetch_pc_next;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state and fetch address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      addr_q   <= addr_next;
    end
  end

  assign imem.imem_req  = (state != IDLE);
  assign imem.imem_addr = addr_q;

  fetch_buffer u_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (pc_src),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign if_valid       = (count != 2'd0);
  assign if_instr       = head.instr;
  assign if_pc          = head.pc;
  assign if_pc_plus_two = pc_plus_two(head.pc);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a memory responder, a program-order
// reference model watching every cycle, and directed scenario tasks.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_src = 1'b0;
  logic        id_ready = 1'b0;
  logic [15:0] jump_address = 16'h0000;
  logic        if_valid;
  logic [15:0] if_instr, if_pc, if_pc_plus_two;

  localparam logic [15:0] RST_PC = 16'h0000;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_src         (pc_src),
    .jump_address   (jump_address),
    .imem           (bus),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus_two (if_pc_plus_two),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_acc  = 0;

  bit mem_hold  = 1'b0;
  bit mem_rand  = 1'b0;
  int mem_delay = 0;

  // Memory: acknowledges a request after a per-request delay, data = addr ^ A5A5.
  initial begin
    int wcnt;
    int cur_delay;
    wcnt = 0;
    cur_delay = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        bus.imem_ack = 1'b0;
        wcnt = 0;
        cur_delay = mem_delay;
      end else if (bus.imem_req && !mem_hold && wcnt >= cur_delay) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = bus.imem_addr ^ 16'hA5A5;
        wcnt = 0;
        cur_delay = mem_rand ? int'($urandom_range(0, 3)) : mem_delay;
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'($urandom);
        if (bus.imem_req) wcnt++;
      end
    end
  end

  // Reference model: decode must see the program-order address stream,
  // occupancy follows live acks minus accepts, flushed on every redirect.
  initial begin
    int          held;
    logic [15:0] exp_pc, fetch_exp, prev_addr, tgt;
    bit          prev_free, cur_live, acc;
    held = 0; exp_pc = RST_PC; fetch_exp = RST_PC; prev_addr = RST_PC;
    prev_free = 1'b1; cur_live = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 0; exp_pc = RST_PC; fetch_exp = RST_PC;
        prev_free = 1'b1; cur_live = 1'b0;
      end else begin
        tgt = jump_address & 16'hFFFE;
        n_cmp++;
        if (prev_free) begin
          if (bus.imem_req !== (held < 2)) begin
            n_fail++;
            $display("FAIL req_issue t=%0t got req=%b want req=%b (queued=%0d)",
                     $time, bus.imem_req, (held < 2), held);
          end
          if (bus.imem_req) cur_live = 1'b1;
        end else if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL req_hold t=%0t got req=%b addr=%h want req=1 addr=%h",
                   $time, bus.imem_req, bus.imem_addr, prev_addr);
        end
        n_cmp++;
        if (if_valid !== (held != 0)) begin
          n_fail++;
          $display("FAIL if_valid t=%0t got %b want %b", $time, if_valid, (held != 0));
        end
        acc = if_valid && id_ready && !pc_src;
        if (acc) begin
          n_cmp++;
          if (if_pc !== exp_pc || if_instr !== (exp_pc ^ 16'hA5A5) ||
              if_pc_plus_two !== exp_pc + 16'd2) begin
            n_fail++;
            $display("FAIL accept t=%0t got pc=%h instr=%h pc2=%h want pc=%h instr=%h pc2=%h",
                     $time, if_pc, if_instr, if_pc_plus_two,
                     exp_pc, exp_pc ^ 16'hA5A5, exp_pc + 16'd2);
          end
          exp_pc = exp_pc + 16'd2;
          held--;
          n_acc++;
        end
        if (bus.imem_req && bus.imem_ack) begin
          if (cur_live && !pc_src) begin
            n_cmp++;
            if (bus.imem_addr !== fetch_exp) begin
              n_fail++;
              $display("FAIL fetch_addr t=%0t got %h want %h", $time, bus.imem_addr, fetch_exp);
            end
            fetch_exp = fetch_exp + 16'd2;
            held++;
          end
          cur_live = 1'b0;
        end
        if (pc_src) begin
          held = 0; exp_pc = tgt; fetch_exp = tgt; cur_live = 1'b0;
        end
        prev_free = !bus.imem_req || bus.imem_ack;
        prev_addr = bus.imem_addr;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; id_ready = 1'b1; pc_src = 1'b0; mem_delay = 0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_bus got req=%b addr=%h want req=0 addr=%h", bus.imem_req, bus.imem_addr, RST_PC);
    end
    n_cmp++;
    if (if_valid !== 1'b0 || if_instr !== 16'h0000 || if_pc !== 16'h0000 || if_pc_plus_two !== 16'h0002) begin
      n_fail++;
      $display("FAIL reset_head got v=%b i=%h pc=%h pc2=%h want v=0 i=0000 pc=0000 pc2=0002",
               if_valid, if_instr, if_pc, if_pc_plus_two);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL first_req got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== 16'(2 * k) || if_pc_plus_two !== 16'(2 * k + 2)) begin
        n_fail++;
        $display("FAIL stream[%0d] got v=%b pc=%h pc2=%h want v=1 pc=%h pc2=%h",
                 k, if_valid, if_pc, if_pc_plus_two, 16'(2 * k), 16'(2 * k + 2));
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] h;
    @(negedge clk);
    h = if_pc;
    id_ready = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus.imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== h) begin
      n_fail++;
      $display("FAIL stall got req=%b v=%b pc=%h want req=0 v=1 pc=%h", bus.imem_req, if_valid, if_pc, h);
    end
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== h + 16'(2 * k)) begin
        n_fail++;
        $display("FAIL drain[%0d] got v=%b pc=%h want v=1 pc=%h", k, if_valid, if_pc, h + 16'(2 * k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_drop();
    logic [15:0] stale;
    mem_hold = 1'b1;
    repeat (4) @(negedge clk);
    stale = bus.imem_addr;
    n_cmp++;
    if (bus.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_pending got req=%b want req=1", bus.imem_req);
    end
    pc_src = 1'b1; jump_address = 16'h1235;
    @(negedge clk);
    pc_src = 1'b0;
    n_cmp++;
    if (if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== stale) begin
      n_fail++;
      $display("FAIL drop_hold got v=%b req=%b addr=%h want v=0 req=1 addr=%h",
               if_valid, bus.imem_req, bus.imem_addr, stale);
    end
    repeat (2) @(negedge clk);
    mem_hold = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h1234 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_retarget got req=%b addr=%h v=%b want req=1 addr=1234 v=0",
               bus.imem_req, bus.imem_addr, if_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 16'h1234 || if_instr !== (16'h1234 ^ 16'hA5A5)) begin
      n_fail++;
      $display("FAIL drop_target got v=%b pc=%h instr=%h want v=1 pc=1234 instr=%h",
               if_valid, if_pc, if_instr, 16'h1234 ^ 16'hA5A5);
    end
  endtask

  task automatic test_redirect_ack();
    id_ready = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (bus.imem_req !== 1'b0 || if_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fill got req=%b v=%b want req=0 v=1", bus.imem_req, if_valid);
    end
    mem_hold = 1'b1; id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.imem_req !== 1'b1 || if_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_req got req=%b v=%b want req=1 v=1", bus.imem_req, if_valid);
    end
    mem_hold = 1'b0; pc_src = 1'b1; jump_address = 16'h4000;
    @(negedge clk);
    pc_src = 1'b0;
    n_cmp++;
    if (if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h4000) begin
      n_fail++;
      $display("FAIL ack_flush got v=%b req=%b addr=%h want v=0 req=1 addr=4000",
               if_valid, bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 16'h4000) begin
      n_fail++;
      $display("FAIL ack_target got v=%b pc=%h want v=1 pc=4000", if_valid, if_pc);
    end
  endtask

  task automatic test_wrap();
    id_ready = 1'b1; pc_src = 1'b1; jump_address = 16'hFFFC;
    @(negedge clk);
    pc_src = 1'b0;
    n_cmp++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'hFFFC) begin
      n_fail++;
      $display("FAIL wrap_req got req=%b addr=%h want req=1 addr=fffc", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 16'hFFFC) begin
      n_fail++;
      $display("FAIL wrap_fffc got v=%b pc=%h want v=1 pc=fffc", if_valid, if_pc);
    end
    @(negedge clk);
    n_cmp++;
    if (if_pc !== 16'hFFFE || if_pc_plus_two !== 16'h0000 || bus.imem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_fffe got pc=%h pc2=%h addr=%h want pc=fffe pc2=0000 addr=0000",
               if_pc, if_pc_plus_two, bus.imem_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_pc_plus_two !== 16'h0002) begin
      n_fail++;
      $display("FAIL wrap_0000 got v=%b pc=%h pc2=%h want v=1 pc=0000 pc2=0002",
               if_valid, if_pc, if_pc_plus_two);
    end
  endtask

  task automatic test_random();
    int acc0;
    acc0 = n_acc;
    mem_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      id_ready     = ($urandom_range(0, 3) != 0);
      pc_src       = ($urandom_range(0, 31) == 0);
      jump_address = 16'($urandom);
    end
    @(negedge clk);
    pc_src = 1'b0; id_ready = 1'b1; mem_rand = 1'b0;
    n_cmp++;
    if (n_acc - acc0 < 100) begin
      n_fail++;
      $display("FAIL random_progress got %0d accepts want at least 100", n_acc - acc0);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    id_ready = 1'b0;
    repeat (10) @(negedge clk);
    mem_hold = 1'b1; id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.imem_req !== 1'b1 || if_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup got req=%b v=%b want req=1 v=1", bus.imem_req, if_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== RST_PC || if_valid !== 1'b0 ||
        if_instr !== 16'h0000 || if_pc !== 16'h0000 || if_pc_plus_two !== 16'h0002) begin
      n_fail++;
      $display("FAIL mid_reset got req=%b addr=%h v=%b i=%h pc=%h pc2=%h want req=0 addr=%h v=0 i=0000 pc=0000 pc2=0002",
               bus.imem_req, bus.imem_addr, if_valid, if_instr, if_pc, if_pc_plus_two, RST_PC);
    end
    mem_hold = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL mid_restart got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, RST_PC);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0002) begin
      n_fail++;
      $display("FAIL mid_resume got v=%b pc=%h want v=1 pc=0002", if_valid, if_pc);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_ack();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
